// File: rtl/register_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_file_sb : two-write-port register file, write-first bypass,     |
// |                    per-register busy scoreboard for multi-cycle ops      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module register_file_sb #(
   parameter int              DATA_W   = 32,
   parameter int              ADDR_W   = 5,
   parameter int              SP_IDX   = 2,
   parameter logic [DATA_W-1:0] SP_INIT = 32'h7fffefe4,
   parameter bit              BYPASS   = 1'b1,
   parameter int              DBG0_IDX = 7,
   parameter int              DBG1_IDX = 28
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              busy1,
   output logic              busy2,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] wa_a,
   input  logic [DATA_W-1:0] wd_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] wa_b,
   input  logic [DATA_W-1:0] wd_b,
   input  logic              rsv,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [ADDR_W:0]   busy_cnt,
   output logic [DATA_W-1:0] dbg0,
   output logic [DATA_W-1:0] dbg1
);

   localparam int c_DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]  r_regs [c_DEPTH];
   logic [c_DEPTH-1:0] r_busy;
   logic [c_DEPTH-1:0] w_busy_nxt;
   logic [ADDR_W:0]    r_busy_cnt;
   logic [ADDR_W:0]    w_cnt_nxt;

   // Port B is written first so a same-address port A write overrides it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else begin
         if (we_b && (wa_b != '0)) begin
            r_regs[wa_b] <= wd_b;
         end
         if (we_a && (wa_a != '0)) begin
            r_regs[wa_a] <= wd_a;
         end
      end
   end

   // A reservation beats a release on the same index.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 1; i < c_DEPTH; i++) begin
         if (rsv && (rsv_addr == ADDR_W'(i))) begin
            w_busy_nxt[i] = 1'b1;
         end else if (we_b && (wa_b == ADDR_W'(i))) begin
            w_busy_nxt[i] = 1'b0;
         end
      end
      w_busy_nxt[0] = 1'b0;
      w_cnt_nxt = '0;
      for (int i = 0; i < c_DEPTH; i++) begin
         w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
      end
   end

   logic [ADDR_W-1:0] w_ra   [2];
   logic [DATA_W-1:0] w_rd   [2];
   logic              w_busy [2];

   assign w_ra[0] = ra1;
   assign w_ra[1] = ra2;

   for (genvar gp = 0; gp < 2; gp++) begin : g_rd
      logic w_hit_a;
      logic w_hit_b;
      logic w_zero;

      assign w_zero  = (w_ra[gp] == '0);
      assign w_hit_a = BYPASS && we_a && (wa_a == w_ra[gp]);
      assign w_hit_b = BYPASS && we_b && (wa_b == w_ra[gp]);

      assign w_rd[gp]   = w_zero  ? '0 :
                          w_hit_a ? wd_a :
                          w_hit_b ? wd_b : r_regs[w_ra[gp]];
      assign w_busy[gp] = !w_zero && r_busy[w_ra[gp]] && !w_hit_b;
   end

   assign rd1      = w_rd[0];
   assign rd2      = w_rd[1];
   assign busy1    = w_busy[0];
   assign busy2    = w_busy[1];
   assign busy_cnt = r_busy_cnt;
   assign dbg0     = r_regs[DBG0_IDX];
   assign dbg1     = r_regs[DBG1_IDX];

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// Directed bench for register_file_sb: one bypassing and one non-bypassing
// instance share every input.
module tb_register_file_sb;

   localparam logic [31:0] SP_INIT = 32'h7fffefe4;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ra1, ra2, wa_a, wa_b, rsv_addr;
   logic [31:0] wd_a, wd_b;
   logic        we_a, we_b, rsv;

   logic [31:0] rd1, rd2, dbg0, dbg1;
   logic        busy1, busy2;
   logic [5:0]  busy_cnt;
   logic [31:0] nb_rd1, nb_rd2, nb_dbg0, nb_dbg1;
   logic        nb_busy1, nb_busy2;
   logic [5:0]  nb_busy_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   register_file_sb #(.BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .busy1(busy1), .busy2(busy2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
      .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .rsv(rsv), .rsv_addr(rsv_addr),
      .busy_cnt(busy_cnt), .dbg0(dbg0), .dbg1(dbg1)
   );

   register_file_sb #(.BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
      .busy1(nb_busy1), .busy2(nb_busy2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
      .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .rsv(rsv), .rsv_addr(rsv_addr),
      .busy_cnt(nb_busy_cnt), .dbg0(nb_dbg0), .dbg1(nb_dbg1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we_a;
      logic [4:0]  wa_a;
      logic [31:0] wd_a;
      logic        we_b;
      logic [4:0]  wa_b;
      logic [31:0] wd_b;
      logic        rsv;
      logic [4:0]  rsv_addr;
      logic [4:0]  ra1;
      logic [31:0] e_rd1;
      logic        e_busy1;
      logic [31:0] e_nb_rd1;
      logic        e_nb_busy1;
      logic [5:0]  e_cnt;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      we_a = 1'b0; wa_a = '0; wd_a = '0;
      we_b = 1'b0; wa_b = '0; wd_b = '0;
      rsv  = 1'b0; rsv_addr = '0;
   endtask

   initial begin
      // Reset state after each vector is the cumulative result of those above it.
      vecs[0]  = '{1'b1, 5'd5,  32'h11111111, 1'b1, 5'd5,  32'h22222222, 1'b0, 5'd0,  5'd5,  32'h11111111, 1'b0, 32'h0,        1'b0, 6'd0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  32'h11111111, 1'b0, 32'h11111111, 1'b0, 6'd0};
      vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 6'd0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 5'd10, 32'h0,        1'b0, 32'h0,        1'b0, 6'd1};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 5'd10, 32'h0,        1'b1, 32'h0,        1'b1, 6'd2};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hABCD0001, 1'b0, 5'd0,  5'd10, 32'hABCD0001, 1'b0, 32'h0,        1'b1, 6'd1};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'h33333333, 1'b1, 5'd11, 5'd11, 32'h33333333, 1'b0, 32'h0,        1'b1, 6'd1};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd11, 32'h33333333, 1'b1, 32'h33333333, 1'b1, 6'd1};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 32'hABCD0001, 1'b0, 32'hABCD0001, 1'b0, 6'd1};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h00000044, 1'b0, 5'd0,  5'd12, 32'h00000044, 1'b0, 32'h0,        1'b0, 6'd1};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 5'd11, 32'h33333333, 1'b1, 32'h33333333, 1'b1, 6'd1};
      vecs[12] = '{1'b1, 5'd11, 32'h00000055, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd11, 32'h00000055, 1'b1, 32'h33333333, 1'b1, 6'd1};
      vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd11, 32'h00000055, 1'b1, 32'h00000055, 1'b1, 6'd1};
      vecs[14] = '{1'b1, 5'd3,  32'h000000A3, 1'b1, 5'd11, 32'h00000B11, 1'b0, 5'd0,  5'd11, 32'h00000B11, 1'b0, 32'h00000055, 1'b1, 6'd0};
      vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  32'h000000A3, 1'b0, 32'h000000A3, 1'b0, 6'd0};

      // Reset with a concurrent write that must be lost.
      idle();
      ra1 = '0; ra2 = '0;
      rst_n = 1'b0;
      we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(31 - i); #1;
         check($sformatf("reset rd1[%0d]", i), rd1, (i == 2) ? SP_INIT : 32'h0);
         check($sformatf("reset nb rd2[%0d]", 31 - i), nb_rd2, (31 - i == 2) ? SP_INIT : 32'h0);
         check($sformatf("reset busy1[%0d]", i), {31'b0, busy1}, 32'h0);
      end
      check("reset busy_cnt", {26'b0, busy_cnt}, 32'h0);
      check("reset dbg0", dbg0, 32'h0);
      check("reset dbg1", dbg1, 32'h0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         we_a = vecs[i].we_a; wa_a = vecs[i].wa_a; wd_a = vecs[i].wd_a;
         we_b = vecs[i].we_b; wa_b = vecs[i].wa_b; wd_b = vecs[i].wd_b;
         rsv  = vecs[i].rsv;  rsv_addr = vecs[i].rsv_addr;
         ra1  = vecs[i].ra1;  ra2 = '0;
         #1;
         check($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
         check($sformatf("v%0d busy1", i), {31'b0, busy1}, {31'b0, vecs[i].e_busy1});
         check($sformatf("v%0d nb rd1", i), nb_rd1, vecs[i].e_nb_rd1);
         check($sformatf("v%0d nb busy1", i), {31'b0, nb_busy1}, {31'b0, vecs[i].e_nb_busy1});
         @(posedge clk); #1;
         check($sformatf("v%0d busy_cnt", i), {26'b0, busy_cnt}, {26'b0, vecs[i].e_cnt});
         check($sformatf("v%0d nb busy_cnt", i), {26'b0, nb_busy_cnt}, {26'b0, vecs[i].e_cnt});
         idle();
      end

      // Fill the scoreboard x1..x31 (x11 is already clear at this point).
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         rsv = 1'b1; rsv_addr = 5'(i);
         @(posedge clk); #1;
         if (i == 16) check("fill cnt@16", {26'b0, busy_cnt}, 32'd16);
      end
      check("fill cnt", {26'b0, busy_cnt}, 32'd31);
      @(negedge clk);
      rsv = 1'b1; rsv_addr = 5'd31; ra1 = 5'd31; ra2 = 5'd1;
      @(posedge clk); #1;
      check("re-reserve cnt", {26'b0, busy_cnt}, 32'd31);
      check("full busy1", {31'b0, busy1}, 32'd1);
      check("full busy2", {31'b0, busy2}, 32'd1);

      // Mid-operation reset, with a reservation presented in the same cycle.
      @(negedge clk);
      rsv = 1'b1; rsv_addr = 5'd5; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      check("midreset cnt", {26'b0, busy_cnt}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(i); #1;
         check($sformatf("midreset busy1[%0d]", i), {31'b0, busy1}, 32'd0);
         check($sformatf("midreset nb busy2[%0d]", i), {31'b0, nb_busy2}, 32'd0);
      end
      ra1 = 5'd5; #1;
      check("midreset rd1 x5", rd1, 32'h0);
      @(negedge clk);
      we_b = 1'b1; wa_b = 5'd4; wd_b = 32'h00000004;
      @(posedge clk); #1;
      idle();
      check("plain we_b cnt", {26'b0, busy_cnt}, 32'd0);

      // Debug taps update one edge after the write.
      @(negedge clk);
      we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h00000007;
      #1;
      check("dbg0 same cycle", dbg0, 32'h0);
      @(posedge clk); #1;
      check("dbg0 after edge", dbg0, 32'h00000007);
      @(negedge clk);
      we_a = 1'b1; wa_a = 5'd28; wd_a = 32'h0000001C;
      #1;
      check("dbg1 same cycle", dbg1, 32'h0);
      @(posedge clk); #1;
      check("dbg1 after edge", dbg1, 32'h0000001C);
      check("dbg0 holds", dbg0, 32'h00000007);
      check("nb dbg1", nb_dbg1, 32'h0000001C);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file_sb.md
# register_file_sb

Parametrised two-write-port register file with write-first bypass and a per-register busy scoreboard. It replaces the single-write-port register file in the RISC-V core's decode stage. Port A is the in-order writeback path. Port B is the late writeback path from multi-cycle units (load, multiply/divide). The scoreboard marks destinations owned by an in-flight multi-cycle operation so decode can stall on read-after-write hazards.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W; index 0 is hard-wired zero
- SP_IDX, 2, index of the stack pointer register
- SP_INIT, 32'h7fffefe4, reset value of register SP_IDX; all other registers reset to 0
- BYPASS, 1, 1 = same-cycle writes are forwarded to read ports; 0 = reads return stored array contents only
- DBG0_IDX, 7, register index driven on dbg0
- DBG1_IDX, 28, register index driven on dbg1

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  combinational read data
- busy1, busy2  out  1  combinational busy status of ra1/ra2
- we_a  in  1  port A write enable
- wa_a  in  ADDR_W  port A write address
- wd_a  in  DATA_W  port A write data
- we_b  in  1  port B write enable; also releases the reservation on wa_b
- wa_b  in  ADDR_W  port B write address
- wd_b  in  DATA_W  port B write data
- rsv  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- busy_cnt  out  ADDR_W+1  registered count of busy registers
- dbg0, dbg1  out  DATA_W  registers DBG0_IDX / DBG1_IDX, unbypassed

## Operation
- Reset (rst_n low at a rising edge):
  - All registers load 0, except SP_IDX, which loads SP_INIT.
  - The busy vector and busy_cnt load 0.
  - Reset dominates any write or reservation presented in the same cycle.
- Register 0:
  - Writes to index 0 are ignored and reservations of index 0 are ignored.
  - Reads of index 0 return 0 and busy = 0, regardless of BYPASS.
- Writes:
  - On a rising edge, reg[wa_a] <= wd_a when we_a is high, and reg[wa_b] <= wd_b when we_b is high.
  - If both ports target the same nonzero address, port A's data is stored; port B still clears busy.
- Scoreboard, per index i != 0, next busy[i]:
  - busy[i] goes to 1 if rsv && rsv_addr == i.
  - Otherwise busy[i] goes to 0 if we_b && wa_b == i.
  - Otherwise busy[i] holds.
  - A reservation and a release on the same index in the same cycle leave it busy (the new reservation wins).
  - A port A write does not change busy.
- busy_cnt:
  - Equals the popcount of the busy vector and is updated on the same edge as the vector.
  - The range is 0..2**ADDR_W-1, so it cannot overflow.
  - Redundant operations leave the count unchanged: reserving an already-busy index, or releasing a non-busy index.
- Reads with BYPASS=1, for each read port and nonzero ra:
  - rd = wd_a if we_a && wa_a == ra.
  - Else rd = wd_b if we_b && wa_b == ra.
  - Else rd = reg[ra].
  - busy = busy[ra] & ~(we_b && wa_b == ra).
- Reads with BYPASS=0: rd = reg[ra] and busy = busy[ra].
- The rsv input never affects same-cycle busy outputs.

## Timing
- Read paths are combinational, with zero-cycle latency from ra / write inputs.
- Write-to-read latency is 1 edge without bypass and 0 with bypass.
- Reservation is visible on busy1/busy2 and busy_cnt one edge after rsv.
- Release is visible on the busy outputs in the same cycle when BYPASS=1, and after 1 edge when BYPASS=0.
- Output values while rst_n is low and before the first edge are the current array state.
- Output values after the reset edge:
  - rd1/rd2 = 0 for every index except SP_IDX, which reads SP_INIT.
  - busy1/busy2 = 0, busy_cnt = 0.
  - dbg0/dbg1 = 0 for the default indices.
- Reset asserted mid-operation discards every outstanding reservation. Any later we_b is a plain write with no count change.

## Test plan
- Reset: drive rst_n=0 for 1 edge, then read every index. Expect reg2 = 32'h7fffefe4, all others 0, and busy_cnt = 0. A concurrent we_a to x5 with 32'hDEADBEEF must be lost.
- Bypass and collision: in one cycle, we_a writes x5 with 32'h11111111 and we_b writes x5 with 32'h22222222, with ra1 = 5.
  - Same cycle: rd1 = 32'h11111111.
  - After the edge: rd1 = 32'h11111111.
  - Repeat with BYPASS=0: the same-cycle read returns the old value 0.
- x0 protection: we_a writes x0 with 32'hFFFFFFFF, and rsv targets x0. Expect rd1 = 0 both in the same cycle and after the edge, busy1 = 0, and busy_cnt = 0.
- Scoreboard lifecycle:
  - rsv x10, then rsv x11. Expect busy_cnt = 2.
  - we_b writes x10 with 32'hABCD0001. Expect busy1 (ra1 = 10) to drop in the same cycle and busy_cnt = 1 after the edge.
  - In one cycle, rsv x11 and we_b to x11. Expect busy_cnt to stay 1 and x11 to stay busy.
- Fill and reset mid-operation:
  - Reserve x1..x31 on consecutive cycles. Expect busy_cnt = 31.
  - Re-reserve x31. Expect busy_cnt to stay 31.
  - Assert rst_n=0 for one edge. Expect busy_cnt = 0 and all busy outputs 0.
- Debug taps: we_a writes x7 with 32'h00000007 and x28 with 32'h0000001C. Expect dbg0/dbg1 to update one edge after each write and not in the write cycle.
